alu_md: RTL
===========

# alu_md

Pipelined-execute arithmetic unit extending the base integer ALU operation set with RV32M-style multiply/divide/remainder. Parametrised in datapath width. Wrapped in a valid/ready handshake so the execute stage can stall on multi-cycle operations. Base operations complete in one cycle; multiply/divide run iteratively over `XLEN` cycles with early-out for divide-by-zero.

## Interface

- `XLEN`, default 32: datapath width; must be a power of two, at least 8.
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `flush` in, 1: abort in-flight operation; drop pending result.
- `in_valid` in, 1: operand/op presented.
- `in_ready` out, 1: unit accepts the operation this cycle.
- `alu_op` in, 5: operation code from `alu_pkg::alu_op_e`.
- `data1`, `data2` in, `XLEN`: operands (rs1, rs2/imm).
- `out_valid` out, 1: `alu_out` holds a result.
- `out_ready` in, 1: consumer takes result this cycle.
- `alu_out` out, `XLEN`: result.
- `busy` out, 1: iterative operation in progress (hazard/stall hint).

## Operation

- **Base ops, codes 0x00–0x0A.** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI (pass `data2`).
  - Shift amount is `data2[$clog2(XLEN)-1:0]`.
  - SLT/SLTU yield 1 or 0, zero-extended.
- **Multiply ops, codes 0x10–0x13.** MUL, MULH, MULHSU, MULHU.
  - 2·XLEN product. MUL returns the low half; the others return the high half.
  - Signedness: MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned.
- **Divide ops, codes 0x14–0x17.** DIV, DIVU, REM, REMU.
  - Restoring shift-subtract on magnitudes, with sign fix-up at the end.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- **Special cases, all resolved in one cycle with no iteration:**
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return `data1`.
  - Signed overflow (`data1 = -2^(XLEN-1)`, `data2 = -1`): DIV returns `data1`; REM returns 0.
- Undefined codes return 0 in one cycle.
- **State machine:** IDLE → BUSY → DONE.
  - IDLE: `in_ready=1`. On accept of a base op, special case, or undefined code, go to DONE. On accept of mul/div, go to BUSY with counter = XLEN−1.
  - BUSY: one iteration per cycle; counter decrements. When the counter reaches 0, apply sign fix-up and go to DONE.
  - DONE: `out_valid=1`; `in_ready=out_ready`. If `out_ready` and `in_valid` are both high, accept the next op in the same cycle (back-to-back). If only `out_ready` is high, go to IDLE. Otherwise hold `alu_out` stable.
- **`flush`** (priority over everything):
  - Next state is IDLE; `out_valid` clears next cycle.
  - `in_valid` in a flush cycle is ignored, and `in_ready` is forced to 0.
- Operands and op are captured at accept. Later changes to the inputs have no effect.

## Timing

- Reset values: state IDLE, `out_valid=0`, `busy=0`, `alu_out=0`, counter 0. `in_ready=1` once reset deasserts.
- Base/special/undefined op accepted at cycle N: `out_valid` at N+1.
- Mul/div accepted at cycle N: `busy` is high for cycles N+1 … N+XLEN, and `out_valid` rises at N+XLEN+1.
  - For XLEN=32, that is 33 cycles accept-to-result.
- Throughput:
  - Base ops: one per cycle while `out_ready` is held high.
  - Mul/div: one per XLEN+1 cycles.
- `in_ready` is combinational from state, `out_ready` and `flush`; it never depends on `in_valid`.
- Reset asserted mid-BUSY: outputs return to reset values asynchronously, and the partial result is discarded.
- Flush in the same cycle as the final iteration: no result is produced.

## Structure

- `alu_pkg` holds:
  - `alu_op_e` (5-bit enum, codes above)
  - `is_md(op)` and `is_signed_*` helper functions
  - the state enum
  - the default `XLEN` constant
- One sub-module, `alu_md_iter`: the iterative shift-add / shift-subtract datapath.
  - Holds accumulator, operand and counter registers.
  - Exposes `start`, `kill`, `done` and `result`.
- Base-op combinational logic and the FSM stay in `alu_md`.

## Test plan

- **Reset/base op:** reset, then ADD 5+7, SRA 0x80000000>>>4, SLTU 1<0xFFFFFFFF → 12, 0xF8000000 and 1 respectively, each with `out_valid` one cycle after accept.
- **Multiply:** MULH 0x80000000×0x80000000 → 0x40000000; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF; MUL 7×−3 → 0xFFFFFFEB. Each arrives exactly 33 cycles after accept with `busy` high for 32 cycles.
- **Divide corners:**
  - DIV −7/2 → −3; REM −7/2 → −1.
  - DIVU 10/0 → 0xFFFFFFFF; REM 10/0 → 10. Both in 1 cycle.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0. Both in 1 cycle.
- **Backpressure:** hold `out_ready=0` for 5 cycles after a result → `alu_out` stable and `in_ready=0`; then raise `out_ready` with a new ADD on `in_valid` → accepted the same cycle, new result the next cycle.
- **Flush:** assert `flush` at cycle 10 of a DIVU → `out_valid` never rises, `busy=0` next cycle; a following ADD completes normally.
- **Reset mid-op:** assert `rst_n=0` during a MUL → all outputs at reset values immediately; no stale result after release.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared types and helpers for the alu_md execute unit:
// op codes, FSM states, op-class predicates, default width.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_SLL    = 5'h02,
    ALU_SLT    = 5'h03,
    ALU_SLTU   = 5'h04,
    ALU_XOR    = 5'h05,
    ALU_SRL    = 5'h06,
    ALU_SRA    = 5'h07,
    ALU_OR     = 5'h08,
    ALU_AND    = 5'h09,
    ALU_LUI    = 5'h0A,
    ALU_MUL    = 5'h10,
    ALU_MULH   = 5'h11,
    ALU_MULHSU = 5'h12,
    ALU_MULHU  = 5'h13,
    ALU_DIV    = 5'h14,
    ALU_DIVU   = 5'h15,
    ALU_REM    = 5'h16,
    ALU_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_md(alu_op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU,
                      ALU_MULHU, ALU_DIV, ALU_DIVU,
                      ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div(alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU,
                      ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_rem(alu_op_e op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_a(alu_op_e op);
    return op inside {ALU_MULH, ALU_MULHSU,
                      ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_signed_b(alu_op_e op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative mul/div datapath: one shift-add or restoring
// shift-subtract step per cycle; ports start/kill/done/result.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic            active;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, opd;
  alu_op_e         op_q;
  logic            neg_p, neg_r;

  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;

  assign sa    = is_signed_a(op) & a[XLEN-1];
  assign sb    = is_signed_b(op) & b[XLEN-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  logic [XLEN:0]   sum, sh, diff;
  logic [XLEN-1:0] hi_n, lo_n;

  // hi:lo is product (mul) or remainder:quotient (div)
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, opd};
    hi_n = sum[XLEN:1];
    lo_n = {sum[0], lo[XLEN-1:1]};
    if (is_div(op_q)) begin
      hi_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod   = neg_p ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo    = neg_p ? -lo_n : lo_n;
    rem    = neg_r ? -hi_n : hi_n;
    result = '0;
    case (op_q)
      ALU_MUL:    result = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = prod[2*XLEN-1:XLEN];
      ALU_DIV,
      ALU_DIVU:   result = quo;
      ALU_REM,
      ALU_REMU:   result = rem;
      default:    result = '0;
    endcase
  end

  assign done = active & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      op_q   <= ALU_ADD;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (kill) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(XLEN - 1);
      hi     <= '0;
      lo     <= a_mag;
      opd    <= b_mag;
      op_q   <= op;
      neg_p  <= sa ^ sb;
      neg_r  <= sa;
    end else if (active) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0)
        active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU with iterative RV32M mul/div behind
// valid/ready; flush aborts, busy flags iterative work.
module alu_md
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  alu_op_e         op;
  logic            accept, go_iter;
  logic            div0, ovf, special;
  logic            it_done;
  logic [XLEN-1:0] it_result, quick;
  logic [SW-1:0]   shamt;

  assign op     = alu_op_e'(alu_op);
  assign shamt  = data2[SW-1:0];
  assign accept = in_valid & in_ready;

  // These resolve without iterating
  assign div0 = is_div(op) & (data2 == '0);
  assign ovf  = (op == ALU_DIV || op == ALU_REM)
              & (data1 == {1'b1, {(XLEN-1){1'b0}}})
              & (&data2);
  assign special = div0 | ovf;
  assign go_iter = accept & is_md(op) & ~special;

  always_comb begin
    quick = '0;
    unique case (1'b1)
      div0: quick = is_rem(op) ? data1 : '1;
      ovf:  quick = (op == ALU_DIV) ? data1 : '0;
      default: begin
        case (op)
          ALU_ADD:  quick = data1 + data2;
          ALU_SUB:  quick = data1 - data2;
          ALU_SLL:  quick = data1 << shamt;
          ALU_SLT:  quick = {{(XLEN-1){1'b0}},
                      $signed(data1) < $signed(data2)};
          ALU_SLTU: quick = {{(XLEN-1){1'b0}},
                      data1 < data2};
          ALU_XOR:  quick = data1 ^ data2;
          ALU_SRL:  quick = data1 >> shamt;
          ALU_SRA:  quick = $signed(data1) >>> shamt;
          ALU_OR:   quick = data1 | data2;
          ALU_AND:  quick = data1 & data2;
          ALU_LUI:  quick = data2;
          default:  quick = '0;
        endcase
      end
    endcase
  end

  alu_md_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (go_iter),
    .kill   (flush),
    .op     (op),
    .a      (data1),
    .b      (data2),
    .done   (it_done),
    .result (it_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:
          if (accept)
            state_d = go_iter ? ST_BUSY : ST_DONE;
        ST_BUSY:
          if (it_done)
            state_d = ST_DONE;
        ST_DONE:
          if (accept)
            state_d = go_iter ? ST_BUSY : ST_DONE;
          else if (out_ready)
            state_d = ST_IDLE;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = ~flush;
      ST_BUSY: busy = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alu_out <= '0;
    else if (flush)
      alu_out <= alu_out;
    else if (accept && !go_iter)
      alu_out <= quick;
    else if (it_done)
      alu_out <= it_result;
  end

endmodule
